// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;
   localparam int unsigned XLEN       = 32;
   localparam int unsigned WORD_BYTES = 4;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      PARK,
      DISCARD
   } fetch_state_t;
endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry park register holding a memory response the output slot could not accept.
module fetch_skid_buf
   import fetch_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic            drain,
   input  logic            flush,
   input  logic [XLEN-1:0] load_instr,
   input  logic [XLEN-1:0] load_pc,
   output logic            full,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] pc
);

   // Flush has priority so a redirect always wins over a same-cycle load.
   always_ff @(posedge clk) begin
      if (rst) begin
         full  <= 1'b0;
         instr <= '0;
         pc    <= '0;
      end else if (flush) begin
         full <= 1'b0;
      end else if (load) begin
         full  <= 1'b1;
         instr <= load_instr;
         pc    <= load_pc;
      end else if (drain) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives the instruction-memory request and fills the IF/ID output slot.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stallF,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [XLEN-1:0] imem_rdata,
   output logic [XLEN-1:0] instructionF,
   output logic [XLEN-1:0] PCF,
   output logic            validF
);

   fetch_state_t    state;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pc_inc;
   logic [XLEN-1:0] pc_tgt;
   logic            consume;
   logic            slot_free;
   logic            skid_load;
   logic            skid_drain;
   logic            skid_full;
   logic [XLEN-1:0] skid_instr;
   logic [XLEN-1:0] skid_pc;

   assign consume    = validF & ~stallF;
   assign slot_free  = ~validF | ~stallF;
   assign pc_inc     = pc + XLEN'(WORD_BYTES);
   assign pc_tgt     = redirect_pc & ~(XLEN'(WORD_BYTES) - XLEN'(1));
   assign skid_load  = ~redirect_valid & (state == REQ) & imem_ack & ~slot_free;
   assign skid_drain = ~redirect_valid & (state == PARK) & consume & skid_full;

   fetch_skid_buf u_skid (
      .clk        (clk),
      .rst        (rst),
      .load       (skid_load),
      .drain      (skid_drain),
      .flush      (redirect_valid),
      .load_instr (imem_rdata),
      .load_pc    (pc_inc),
      .full       (skid_full),
      .instr      (skid_instr),
      .pc         (skid_pc)
   );

   // imem_req/imem_addr are held untouched whenever a request is still in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         pc           <= RESET_PC;
         imem_req     <= 1'b0;
         imem_addr    <= '0;
         instructionF <= '0;
         PCF          <= '0;
         validF       <= 1'b0;
      end else if (redirect_valid) begin
         pc     <= pc_tgt;
         validF <= 1'b0;
         if ((state == REQ || state == DISCARD) && !imem_ack) begin
            state <= DISCARD;
         end else begin
            state     <= REQ;
            imem_req  <= 1'b1;
            imem_addr <= pc_tgt;
         end
      end else begin
         case (state)
            IDLE: begin
               state     <= REQ;
               imem_req  <= 1'b1;
               imem_addr <= pc;
            end
            REQ: begin
               if (imem_ack) begin
                  pc <= pc_inc;
                  if (slot_free) begin
                     instructionF <= imem_rdata;
                     PCF          <= pc_inc;
                     validF       <= 1'b1;
                     imem_addr    <= pc_inc;
                  end else begin
                     state    <= PARK;
                     imem_req <= 1'b0;
                  end
               end else if (consume) begin
                  validF <= 1'b0;
               end
            end
            PARK: begin
               if (skid_drain) begin
                  instructionF <= skid_instr;
                  PCF          <= skid_pc;
                  state        <= REQ;
                  imem_req     <= 1'b1;
                  imem_addr    <= pc;
               end
            end
            DISCARD: begin
               if (consume) begin
                  validF <= 1'b0;
               end
               if (imem_ack) begin
                  state     <= REQ;
                  imem_addr <= pc;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage with a wait-state instruction-memory model.
module tb_fetch_stage;

   localparam logic [31:0] KEY = 32'hA5A5_A5A5;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pcf;
   } sb_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stallF = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        imem_req, imem_ack;
   logic [31:0] imem_addr, imem_rdata, instructionF, PCF;
   logic        validF;

   logic        imem_req2, imem_ack2, validF2;
   logic [31:0] imem_addr2, imem_rdata2, instructionF2, PCF2;

   int          wait_cycles = 0;
   int          mem_cnt;
   int          n_cmp = 0;
   int          n_err = 0;
   sb_t         sb[$];

   always #5 clk = ~clk;

   fetch_stage dut (
      .clk            (clk),
      .rst            (rst),
      .stallF         (stallF),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .instructionF   (instructionF),
      .PCF            (PCF),
      .validF         (validF)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk            (clk),
      .rst            (rst),
      .stallF         (1'b0),
      .redirect_valid (1'b0),
      .redirect_pc    (32'h0),
      .imem_req       (imem_req2),
      .imem_addr      (imem_addr2),
      .imem_ack       (imem_ack2),
      .imem_rdata     (imem_rdata2),
      .instructionF   (instructionF2),
      .PCF            (PCF2),
      .validF         (validF2)
   );

   // Memory model: acks after wait_cycles idle cycles, data = addr ^ KEY.
   always @(posedge clk) begin
      if (rst || !imem_req || imem_ack) mem_cnt <= 0;
      else                              mem_cnt <= mem_cnt + 1;
   end
   assign imem_ack    = imem_req && (mem_cnt == wait_cycles);
   assign imem_rdata  = imem_addr ^ KEY;
   assign imem_ack2   = imem_req2;
   assign imem_rdata2 = imem_addr2 ^ KEY;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_seq(input logic [31:0] start, input int n);
      sb.delete();
      for (int i = 0; i < n; i++) begin
         logic [31:0] a;
         a = start + 32'(4 * i);
         sb.push_back('{instr: a ^ KEY, pcf: a + 32'd4});
      end
   endtask

   task automatic do_reset(input int w, input bit check_state);
      rst = 1'b1;
      stallF = 1'b0;
      redirect_valid = 1'b0;
      wait_cycles = w;
      tick();
      tick();
      if (check_state) begin
         chk("rst_validF", 32'(validF), 32'd0);
         chk("rst_req", 32'(imem_req), 32'd0);
         chk("rst_instr", instructionF, 32'd0);
         chk("rst_pcf", PCF, 32'd0);
      end
      push_seq(32'h0, 200);
      rst = 1'b0;
   endtask

   // Every consumed slot is checked in order against the expected stream.
   always @(negedge clk) begin
      if (!rst && validF && !stallF) begin
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL sb_underflow: got PCF %h expected no instruction", PCF);
         end else begin
            sb_t e;
            e = sb.pop_front();
            chk("sb_instr", instructionF, e.instr);
            chk("sb_pcf", PCF, e.pcf);
         end
      end
   end

   initial begin
      int vcount;

      // Zero-wait streaming, plus reset-PC wrap on the second instance.
      do_reset(0, 1'b1);
      tick();
      chk("a_addr0", imem_addr, 32'h0);
      chk("a_req0", 32'(imem_req), 32'd1);
      chk("w_addr0", imem_addr2, 32'hFFFF_FFFC);
      tick();
      chk("a_addr1", imem_addr, 32'h4);
      chk("a_pcf1", PCF, 32'h4);
      chk("w_addr1", imem_addr2, 32'h0);
      chk("w_pcf", PCF2, 32'h0);
      chk("w_instr", instructionF2, 32'hFFFF_FFFC ^ KEY);
      tick();
      chk("a_addr2", imem_addr, 32'h8);
      chk("a_pcf2", PCF, 32'h8);
      tick();
      chk("a_pcf3", PCF, 32'hC);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("a_valid_cont", 32'(validF), 32'd1);
      end

      // Three wait states: address held, one instruction per four cycles.
      do_reset(3, 1'b1);
      tick();
      for (int i = 0; i < 4; i++) begin
         chk("b_addr_hold", imem_addr, 32'h0);
         chk("b_req_hold", 32'(imem_req), 32'd1);
         tick();
      end
      vcount = 0;
      for (int i = 0; i < 16; i++) begin
         if (validF) vcount++;
         tick();
      end
      chk("b_valid_rate", 32'(vcount), 32'd4);

      // Five-cycle stall mid-stream parks exactly one response.
      do_reset(0, 1'b1);
      for (int i = 0; i < 6; i++) tick();
      chk("c_pcf_pre", PCF, 32'd20);
      stallF = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("c_frozen_pcf", PCF, 32'd20);
         chk("c_frozen_instr", instructionF, 32'd16 ^ KEY);
         chk("c_parked_req", 32'(imem_req), 32'd0);
      end
      stallF = 1'b0;
      tick();
      chk("c_drain_pcf", PCF, 32'd24);
      tick();
      chk("c_resume_pcf", PCF, 32'd28);
      for (int i = 0; i < 6; i++) tick();

      // Redirect while a two-wait request is pending.
      do_reset(2, 1'b0);
      tick();
      tick();
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0103;
      push_seq(32'h100, 100);
      tick();
      redirect_valid = 1'b0;
      chk("d_disc_req", 32'(imem_req), 32'd1);
      chk("d_disc_addr", imem_addr, 32'h0);
      chk("d_disc_valid", 32'(validF), 32'd0);
      tick();
      chk("d_new_addr", imem_addr, 32'h100);
      chk("d_stale_valid", 32'(validF), 32'd0);
      tick();
      tick();
      chk("d_wait_valid", 32'(validF), 32'd0);
      tick();
      chk("d_first_valid", 32'(validF), 32'd1);
      chk("d_first_pcf", PCF, 32'h104);
      for (int i = 0; i < 6; i++) tick();

      // Redirect together with stall while PARK holds an entry.
      do_reset(0, 1'b0);
      for (int i = 0; i < 6; i++) tick();
      stallF = 1'b1;
      tick();
      chk("e_parked", 32'(imem_req), 32'd0);
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0200;
      push_seq(32'h200, 100);
      tick();
      chk("e_flush_valid", 32'(validF), 32'd0);
      chk("e_req", 32'(imem_req), 32'd1);
      chk("e_addr", imem_addr, 32'h200);
      redirect_valid = 1'b0;
      stallF = 1'b0;
      tick();
      chk("e_resume_pcf", PCF, 32'h204);
      for (int i = 0; i < 6; i++) tick();

      // Random stalls with one wait state; scoreboard checks ordering.
      do_reset(1, 1'b0);
      for (int i = 0; i < 60; i++) begin
         stallF = 1'($urandom_range(0, 2) == 0);
         tick();
      end
      stallF = 1'b0;
      for (int i = 0; i < 4; i++) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
